// File: rtl/riscv_stall_ctrl_if.sv
// riscv_stall_ctrl_if: signal bundle between the pipeline stages and the hazard controller.
// master = pipeline side (raises hazards), slave = controller side (drives stall/flush).
interface riscv_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_load_use;
    logic             ex_busy;
    logic             dmem_req;
    logic             dmem_ack;
    logic             br_taken;
    logic [4:0]       stall;
    logic             flush;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_load_use, ex_busy, dmem_req, dmem_ack, br_taken,
        input  stall, flush, dmem_timeout, stall_cnt
    );
    modport slave (
        input  id_load_use, ex_busy, dmem_req, dmem_ack, br_taken,
        output stall, flush, dmem_timeout, stall_cnt
    );
endinterface

// File: rtl/riscv_stall_ctrl.sv
// riscv_stall_ctrl: 5-stage pipeline hazard controller producing the stall vector,
// branch flush pulse, memory-wait watchdog and a saturating stall-cycle counter.
module riscv_stall_ctrl #(
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    riscv_stall_ctrl_if.slave ctrl
);
    typedef enum logic [1:0] {IDLE, LOAD_USE, MEM_WAIT} state_e;
    localparam logic [2:0] LU_MAX   = 3'(LU_CYCLES);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);
    localparam logic [4:0] ST_MEM   = 5'b01111;
    localparam logic [4:0] ST_EX    = 5'b00111;
    localparam logic [4:0] ST_LU    = 5'b00011;
    state_e           state_q;
    logic [2:0]       lu_cnt_q;
    logic [7:0]       wait_cnt_q;
    logic             flush_q, flush_pend_q, tmo_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             mem_stall, lu_hit, br_req;
    logic [4:0]       stall_d;
    always_comb begin
        mem_stall = ctrl.dmem_req & ~ctrl.dmem_ack;
        // a load-use hazard seen while flushing belongs to a squashed instruction
        lu_hit    = ctrl.id_load_use & ~flush_q;
        br_req    = ctrl.br_taken | flush_pend_q;
        stall_d   = (state_q == MEM_WAIT || mem_stall) ? ST_MEM :
                    ctrl.ex_busy ? ST_EX :
                    (state_q == LOAD_USE || lu_hit) ? ST_LU : 5'b00000;
    end
    assign ctrl.stall        = rst_ni ? stall_d : 5'b00000;
    assign ctrl.flush        = flush_q;
    assign ctrl.dmem_timeout = tmo_q;
    assign ctrl.stall_cnt    = stall_cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            lu_cnt_q     <= 3'd0;
            wait_cnt_q   <= 8'd0;
            flush_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            tmo_q        <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            tmo_q        <= 1'b0;
            // a branch resolved under an ID/EX hold waits until that stage moves again
            flush_q      <= br_req & ~stall_d[2];
            flush_pend_q <= br_req & stall_d[2];
            if (stall_d != 5'b00000 && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (mem_stall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end else if (!ctrl.ex_busy && lu_hit && LU_MAX > 3'd1) begin
                        state_q  <= LOAD_USE;
                        lu_cnt_q <= 3'd1;
                    end
                end
                LOAD_USE: begin
                    if (mem_stall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end else if (!ctrl.ex_busy) begin
                        lu_cnt_q <= lu_cnt_q + 3'd1;
                        if (lu_cnt_q + 3'd1 >= LU_MAX)
                            state_q <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (ctrl.dmem_ack) begin
                        state_q <= IDLE;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        state_q <= IDLE;
                        tmo_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_stall_ctrl.sv
// tb_riscv_stall_ctrl: directed scoreboard bench; driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_riscv_stall_ctrl;
    localparam int CNT_W = 4;
    typedef struct {
        logic [4:0] stall;
        logic       flush;
        logic       tmo;
        int         cnt;
        string      name;
    } exp_t;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    riscv_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();
    riscv_stall_ctrl #(.LU_CYCLES(2), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .ctrl   (bus)
    );
    task automatic chk(input string nm, input string fld, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "stall", int'(bus.stall), int'(e.stall));
            chk(e.name, "flush", int'(bus.flush), int'(e.flush));
            chk(e.name, "dmem_timeout", int'(bus.dmem_timeout), int'(e.tmo));
            if (e.cnt >= 0) chk(e.name, "stall_cnt", int'(bus.stall_cnt), e.cnt);
        end
    end
    task automatic cyc(input string nm, input logic rst, input logic lu, ex, req, ack, br,
                       input logic [4:0] st, input logic fl, tm, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_ni = rst;
        bus.id_load_use = lu;
        bus.ex_busy = ex;
        bus.dmem_req = req;
        bus.dmem_ack = ack;
        bus.br_taken = br;
        e = '{st, fl, tm, cnt, nm};
        q.push_back(e);
    endtask
    task automatic do_reset(input string nm);
        cyc(nm, 1'b0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
    endtask
    initial begin
        bus.id_load_use = 1'b0;
        bus.ex_busy = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;
        repeat (2) @(posedge clk);
        cyc("idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc("mw_pre", 1, 0, 0, 1, 0, 0, 5'b01111, 0, 0, i);
        cyc("rst_mid", 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0);
        cyc("post_rst0", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("post_rst1", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("lu_a", 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0, 0);
        cyc("lu_b", 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 1);
        cyc("lu_end", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 2);
        cyc("lu_idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 2);
        do_reset("rst_mw");
        for (int i = 0; i < 3; i++) cyc("mw", 1, 0, 0, 1, 0, 0, 5'b01111, 0, 0, i);
        cyc("mw_ack", 1, 0, 0, 1, 1, 0, 5'b01111, 0, 0, 3);
        cyc("mw_done", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 4);
        cyc("zero_wait", 1, 0, 0, 1, 1, 0, 5'b00000, 0, 0, 4);
        do_reset("rst_tmo");
        for (int i = 0; i < 9; i++) cyc("tmo_wait", 1, 0, 0, 1, 0, 0, 5'b01111, 0, 0, i);
        cyc("tmo_pulse", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 9);
        cyc("tmo_after", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 9);
        do_reset("rst_pri");
        cyc("pri_all", 1, 1, 1, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("pri_ack", 1, 0, 1, 1, 1, 0, 5'b01111, 0, 0, 1);
        cyc("pri_ex", 1, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 2);
        cyc("pri_idle", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3);
        do_reset("rst_lux");
        cyc("lux_a", 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0, 0);
        cyc("lux_ex", 1, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 1);
        cyc("lux_b", 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 2);
        cyc("lux_end", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3);
        cyc("lum_a", 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0, 3);
        cyc("lum_mem", 1, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 4);
        cyc("lum_ack", 1, 0, 0, 1, 1, 0, 5'b01111, 0, 0, 5);
        cyc("lum_end", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 6);
        do_reset("rst_br");
        cyc("br_busy0", 1, 0, 1, 0, 0, 1, 5'b00111, 0, 0, 0);
        cyc("br_busy1", 1, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 1);
        cyc("br_busy2", 1, 0, 1, 0, 0, 1, 5'b00111, 0, 0, 2);
        cyc("br_drop", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3);
        cyc("br_flush", 1, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 3);
        cyc("br_once", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3);
        cyc("br_free", 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 3);
        cyc("br_free_fl", 1, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 3);
        cyc("br_free_end", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3);
        cyc("brlu_br", 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 3);
        cyc("brlu_sq", 1, 1, 0, 0, 0, 0, 5'b00000, 1, 0, 3);
        cyc("brlu_end", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3);
        do_reset("rst_sat");
        for (int i = 0; i < 20; i++) cyc("sat", 1, 0, 1, 0, 0, 0, 5'b00111, 0, 0, (i > 15) ? 15 : i);
        cyc("sat_end", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 15);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
